// File: rtl/pvt_measure_scheduler.sv
// Round-robin PVT oscillator frequency sampler: settle, count synchronized edges over a fixed window, report.
// Result valid SETTLE_CYCLES+WINDOW_CYCLES cycles after selection; REPORT holds all fields until result_ready.
module pvt_measure_scheduler #(
  parameter int NUM_SRC       = 4,
  parameter int SRC_W         = 2,
  parameter int CNT_W         = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               start,
  input  logic               continuous,
  output logic [SRC_W-1:0]   sel,
  output logic               div_rst_n,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CNT_W-1:0]   result_count,
  output logic [SRC_W-1:0]   result_src,
  output logic               result_ovf
);

  localparam int MAX_CYC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         sync_q, sync_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic [SRC_W-1:0]   res_src_q, res_src_d;
  logic               res_ovf_q, res_ovf_d;

  logic               edge_pulse;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               ovf_nxt;
  logic [SRC_W:0]     pick_low;
  logic [SRC_W:0]     pick_up;

  // Returns {found, index} of the lowest set mask bit at or above base.
  function automatic logic [SRC_W:0] pick_src(input logic [NUM_SRC-1:0] mask, input int base);
    logic [SRC_W:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mask[i] && (i >= base)) begin
        r = {1'b1, SRC_W'(i)};
      end
    end
    return r;
  endfunction

  assign pick_low = pick_src(src_en, 0);
  assign pick_up  = pick_src(src_en, int'(sel_q) + 1);

  // The chain keeps shifting in SETTLE so the previous source drains out before COUNT.
  assign sync_d     = {sync_q[1:0], src_in[sel_q]};
  assign edge_pulse = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (edge_pulse) begin
      if (cnt_q == '1) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sync_q    <= '0;
      res_cnt_q <= '0;
      res_src_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sync_q    <= sync_d;
      res_cnt_q <= res_cnt_d;
      res_src_q <= res_src_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_cnt_d = res_cnt_q;
    res_src_d = res_src_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (start && pick_low[SRC_W]) begin
          state_d = SETTLE;
          sel_d   = pick_low[SRC_W-1:0];
          tmr_d   = '0;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = COUNT;
          tmr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      COUNT: begin
        cnt_d = cnt_nxt;
        ovf_d = ovf_nxt;
        if (tmr_q == WINDOW_LAST) begin
          state_d   = REPORT;
          tmr_d     = '0;
          res_cnt_d = cnt_nxt;
          res_src_d = sel_q;
          res_ovf_d = ovf_nxt;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      REPORT: begin
        if (result_ready) begin
          tmr_d = '0;
          if (pick_up[SRC_W]) begin
            state_d = SETTLE;
            sel_d   = pick_up[SRC_W-1:0];
          end else if (continuous && pick_low[SRC_W]) begin
            state_d = SETTLE;
            sel_d   = pick_low[SRC_W-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    div_rst_n    = (state_q == COUNT);
    result_valid = (state_q == REPORT);
  end

  assign sel          = sel_q;
  assign result_count = res_cnt_q;
  assign result_src   = res_src_q;
  assign result_ovf   = res_ovf_q;

endmodule

// File: tb/tb_pvt_measure_scheduler.sv
// Bench for pvt_measure_scheduler: randomized oscillator periods, masks and stalls against a rule-level model.
module tb_pvt_measure_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_in;
  logic [3:0]  src_en;
  logic        start;
  logic        continuous;
  logic        result_ready;

  logic [1:0]  sel;
  logic        div_rst_n;
  logic        busy;
  logic        result_valid;
  logic [15:0] result_count;
  logic [1:0]  result_src;
  logic        result_ovf;

  logic [1:0]  s_sel;
  logic        s_div_rst_n;
  logic        s_busy;
  logic        s_result_valid;
  logic [3:0]  s_result_count;
  logic [1:0]  s_result_src;
  logic        s_result_ovf;

  int checks = 0;
  int failures = 0;
  int period [4];
  int phase [4];
  int tick;
  int last_nres;

  pvt_measure_scheduler #(.NUM_SRC(4), .SRC_W(2), .CNT_W(16), .WINDOW_CYCLES(1024), .SETTLE_CYCLES(8)) dut (
    .clk_in(clk), .rst(rst), .src_in(src_in), .src_en(src_en), .start(start), .continuous(continuous),
    .sel(sel), .div_rst_n(div_rst_n), .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_count(result_count), .result_src(result_src), .result_ovf(result_ovf));

  pvt_measure_scheduler #(.NUM_SRC(4), .SRC_W(2), .CNT_W(4), .WINDOW_CYCLES(1024), .SETTLE_CYCLES(8)) dut_s (
    .clk_in(clk), .rst(rst), .src_in(src_in), .src_en(src_en), .start(start), .continuous(continuous),
    .sel(s_sel), .div_rst_n(s_div_rst_n), .busy(s_busy), .result_valid(s_result_valid), .result_ready(result_ready),
    .result_count(s_result_count), .result_src(s_result_src), .result_ovf(s_result_ovf));

  initial forever #5 clk = ~clk;

  // Free-running square-wave oscillators, updated mid low phase of clk.
  initial begin
    tick = 0;
    src_in = '0;
    for (int i = 0; i < 4; i++) begin
      period[i] = 0;
      phase[i]  = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      tick++;
      for (int i = 0; i < 4; i++) begin
        if (period[i] == 0) src_in[i] = 1'b0;
        else src_in[i] = (((tick + phase[i]) % period[i]) < (period[i] / 2));
      end
    end
  end

  function automatic int lowest_from(input logic [3:0] m, input int base);
    for (int i = 0; i < 4; i++) begin
      if (i >= base && m[i]) return i;
    end
    return -1;
  endfunction

  // True when count c is within one edge of the ideal 1024/P edges.
  function automatic bit count_ok(input int c, input int p);
    if (p == 0) return (c == 0);
    return (c * p >= 1024 - p) && (c * p <= 1024 + p);
  endfunction

  task automatic set_periods(input int p0, input int p1, input int p2, input int p3);
    period[0] = p0; period[1] = p1; period[2] = p2; period[3] = p3;
    for (int i = 0; i < 4; i++) phase[i] = $urandom_range(0, 255);
  endtask

  task automatic sweep(input logic [3:0] mask0, input bit cont, input int max_res,
                       input int stall_min, input int stall_max, input bit chg_mask);
    int cur, nxt, cyc, bad_sel, bad_div, bad_busy, bad_hold, stall, nres, p, e;
    logic [15:0] cnt0;
    logic [1:0]  src0;
    logic        ovf0;
    logic [3:0]  m;
    src_en = mask0;
    continuous = cont;
    result_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur = lowest_from(mask0, 0);
    nres = 0;
    while (cur >= 0 && nres < max_res) begin
      cyc = 0; bad_sel = 0; bad_div = 0; bad_busy = 0;
      while (result_valid !== 1'b1 && cyc < 1200) begin
        if (sel !== 2'(cur)) bad_sel++;
        if (div_rst_n !== (cyc >= 8 && cyc < 1032)) bad_div++;
        if (busy !== 1'b1) bad_busy++;
        if (chg_mask && cyc == 600) src_en = 4'($urandom_range(0, 15));
        start = (cyc == 300);
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      checks++;
      if (cyc !== 1032) begin
        failures++;
        $display("FAIL latency src=%0d: got %0d cycles, expected 1032", cur, cyc);
        if (cyc >= 1200) return;
      end
      checks++;
      if (bad_sel !== 0) begin failures++; $display("FAIL sel_stable: %0d cycles with sel != %0d", bad_sel, cur); end
      checks++;
      if (bad_div !== 0) begin failures++; $display("FAIL div_rst_n_window: %0d wrong cycles for src %0d", bad_div, cur); end
      checks++;
      if (bad_busy !== 0) begin failures++; $display("FAIL busy_measure: %0d cycles with busy low", bad_busy); end
      checks++;
      if (result_src !== 2'(cur)) begin failures++; $display("FAIL result_src: got %0d expected %0d", result_src, cur); end
      p = period[cur];
      checks++;
      if (!count_ok(int'(result_count), p)) begin
        failures++;
        $display("FAIL result_count src=%0d: got %0d expected about %0d", cur, result_count, (p == 0) ? 0 : 1024 / p);
      end
      checks++;
      if (result_ovf !== 1'b0) begin failures++; $display("FAIL result_ovf: got %0d expected 0", result_ovf); end
      checks++;
      if (div_rst_n !== 1'b0) begin failures++; $display("FAIL div_rst_n_report: got %0d expected 0", div_rst_n); end
      e = (p == 0) ? 0 : 1024 / p;
      checks++;
      if (s_result_valid !== 1'b1) begin failures++; $display("FAIL sat_valid: got %0d expected 1", s_result_valid); end
      checks++;
      if (e >= 20) begin
        if (s_result_count !== 4'd15 || s_result_ovf !== 1'b1) begin
          failures++;
          $display("FAIL sat_count: got %0d ovf %0d, expected 15 ovf 1", s_result_count, s_result_ovf);
        end
      end else if (!count_ok(int'(s_result_count), p) || s_result_ovf !== 1'b0) begin
        failures++;
        $display("FAIL sat_small_count: got %0d ovf %0d, expected about %0d ovf 0", s_result_count, s_result_ovf, e);
      end
      cnt0 = result_count; src0 = result_src; ovf0 = result_ovf;
      stall = $urandom_range(stall_min, stall_max);
      bad_hold = 0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (result_valid !== 1'b1 || result_count !== cnt0 || result_src !== src0 || result_ovf !== ovf0 ||
            div_rst_n !== 1'b0 || sel !== 2'(cur) || busy !== 1'b1) bad_hold++;
      end
      checks++;
      if (bad_hold !== 0) begin failures++; $display("FAIL backpressure_hold: %0d of %0d stall cycles disturbed", bad_hold, stall); end
      m = src_en;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      checks++;
      if (result_valid !== 1'b0) begin failures++; $display("FAIL valid_drop: got %0d expected 0", result_valid); end
      nres++;
      nxt = lowest_from(m, cur + 1);
      if (nxt < 0 && cont) nxt = lowest_from(m, 0);
      cur = nxt;
    end
    last_nres = nres;
    if (cur < 0) begin
      checks++;
      if (busy !== 1'b0 || div_rst_n !== 1'b0) begin
        failures++;
        $display("FAIL sweep_end_idle: busy %0d div_rst_n %0d, expected 0 0", busy, div_rst_n);
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; result_ready = 1'b0; src_en = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++;
    if (div_rst_n !== 1'b0) begin failures++; $display("FAIL reset_div_rst_n: got %0d expected 0", div_rst_n); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0d expected 0", result_valid); end
    checks++;
    if (result_count !== 16'd0 || result_src !== 2'd0 || result_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_result: got count %0d src %0d ovf %0d, expected 0 0 0", result_count, result_src, result_ovf);
    end
    bad = 0;
    src_en = 4'b1111;
    result_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || div_rst_n !== 1'b0 || result_valid !== 1'b0 || sel !== 2'd0) bad++;
    end
    result_ready = 1'b0;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL idle_hold: %0d cycles left reset values", bad); end
  endtask

  task automatic test_single_source();
    set_periods(0, 0, 8, 0);
    sweep(4'b0100, 1'b0, 8, 0, 0, 1'b0);
    checks++;
    if (last_nres !== 1) begin failures++; $display("FAIL single_results: got %0d expected 1", last_nres); end
  endtask

  task automatic test_round_robin();
    set_periods(8, 16, 4, 32);
    sweep(4'b1011, 1'b0, 8, 0, 2, 1'b0);
    checks++;
    if (last_nres !== 3) begin failures++; $display("FAIL rr_results: got %0d expected 3", last_nres); end
  endtask

  task automatic test_back_to_back_backpressure();
    set_periods(16, 8, 32, 16);
    sweep(4'b0110, 1'b0, 8, 50, 50, 1'b0);
    checks++;
    if (last_nres !== 2) begin failures++; $display("FAIL bp_results: got %0d expected 2", last_nres); end
  endtask

  task automatic test_saturation();
    set_periods(4, 0, 0, 0);
    sweep(4'b0001, 1'b0, 8, 0, 0, 1'b0);
    checks++;
    if (s_result_count !== 4'd15 || s_result_ovf !== 1'b1) begin
      failures++;
      $display("FAIL saturation_hold: got %0d ovf %0d expected 15 ovf 1", s_result_count, s_result_ovf);
    end
  endtask

  task automatic test_continuous_reset();
    int bad;
    set_periods(8, 16, 0, 0);
    sweep(4'b0011, 1'b1, 3, 0, 3, 1'b0);
    repeat (520) @(negedge clk);
    checks++;
    if (sel !== 2'd1 || div_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL continuous_wrap: sel %0d div_rst_n %0d, expected 1 1", sel, div_rst_n);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || sel !== 2'd0 || div_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_count_reset: busy %0d valid %0d sel %0d div %0d, expected 0 0 0 0", busy, result_valid, sel, div_rst_n);
    end
    bad = 0;
    result_ready = 1'b1;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL no_stale_result: %0d cycles active after reset", bad); end
    src_en = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b0 || div_rst_n !== 1'b0) bad++;
      @(negedge clk);
    end
    result_ready = 1'b0;
    continuous = 1'b0;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL empty_mask_start: %0d cycles busy", bad); end
  endtask

  task automatic test_random();
    int ptab [7] = '{0, 4, 8, 16, 32, 128, 256};
    logic [3:0] m;
    for (int it = 0; it < 4; it++) begin
      set_periods(ptab[$urandom_range(0, 6)], ptab[$urandom_range(0, 6)],
                  ptab[$urandom_range(0, 6)], ptab[$urandom_range(0, 6)]);
      m = 4'($urandom_range(1, 15));
      sweep(m, 1'($urandom_range(0, 1)), 4, 0, 6, 1'($urandom_range(0, 1)));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      continuous = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; result_ready = 1'b0; src_en = 4'b0000;
    last_nres = 0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_back_to_back_backpressure();
    test_saturation();
    test_continuous_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
